// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage RV32 pipeline: operand forwarding, load-use stall,
// multi-cycle MDU wait with watchdog, data-memory wait states and a stall counter.
module hazard_unit_mc #(
  parameter int REG_FILE_ADDRESS_WIDTH = 5,
  parameter int MDU_TIMEOUT            = 64,
  parameter int PERF_WIDTH             = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs1D,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs2D,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs1E,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs2E,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdE,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdM,
  input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdW,
  input  logic                              RegWriteM,
  input  logic                              RegWriteW,
  input  logic [1:0]                        ResultSrcE,
  input  logic                              PCSrcE,
  input  logic                              MduStartE,
  input  logic                              MduDoneE,
  input  logic                              DMemReqM,
  input  logic                              DMemReadyM,
  input  logic                              PerfClr,
  output logic [1:0]                        ForwardAE,
  output logic [1:0]                        ForwardBE,
  output logic                              StallFetch,
  output logic                              StallDecode,
  output logic                              StallExecute,
  output logic                              StallMemory,
  output logic                              FlushDecode,
  output logic                              FlushExecute,
  output logic                              FlushMemory,
  output logic                              FlushWriteback,
  output logic                              MduBusy,
  output logic                              MduTimeout,
  output logic [PERF_WIDTH-1:0]             StallCycles
);

  // Counter only needs to reach MDU_TIMEOUT-1, where the watchdog fires.
  localparam int CNT_W = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_TIMEOUT - 1);

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      busy_cnt_q, busy_cnt_d;
  logic                  timeout_q, timeout_d;
  logic [PERF_WIDTH-1:0] perf_q, perf_d;

  logic mem_stall;
  logic mdu_stall;
  logic lu;
  logic timeout_hit;

  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != '0) && (Rs1E == RdM)) begin
      ForwardAE = 2'b10;
    end else if (RegWriteW && (RdW != '0) && (Rs1E == RdW)) begin
      ForwardAE = 2'b01;
    end
    if (RegWriteM && (RdM != '0) && (Rs2E == RdM)) begin
      ForwardBE = 2'b10;
    end else if (RegWriteW && (RdW != '0) && (Rs2E == RdW)) begin
      ForwardBE = 2'b01;
    end
  end

  assign lu = (ResultSrcE == 2'b01) && (RdE != '0) &&
              (((Rs1D != '0) && (Rs1D == RdE)) || ((Rs2D != '0) && (Rs2D == RdE)));

  assign mem_stall   = DMemReqM & ~DMemReadyM;
  assign timeout_hit = (state_q == MDU_WAIT) && (busy_cnt_q == CNT_LAST) && !MduDoneE;
  assign mdu_stall   = ((state_q == RUN) && MduStartE && !MduDoneE) ||
                       ((state_q == MDU_WAIT) && !MduDoneE && !timeout_hit);

  assign StallFetch     = mem_stall | mdu_stall | lu;
  assign StallDecode    = StallFetch;
  assign StallExecute   = mem_stall | mdu_stall;
  assign StallMemory    = mem_stall;
  assign FlushWriteback = mem_stall;
  assign FlushMemory    = mdu_stall & ~mem_stall;
  // Bubbles and redirects only take effect when Execute is allowed to advance.
  assign FlushExecute   = (lu | PCSrcE) & ~StallExecute;
  assign FlushDecode    = PCSrcE & ~StallExecute;

  assign MduBusy     = (state_q == MDU_WAIT);
  assign MduTimeout  = timeout_q;
  assign StallCycles = perf_q;

  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    timeout_d  = timeout_q;
    unique case (state_q)
      RUN: begin
        if (MduStartE && !MduDoneE) begin
          state_d    = MDU_WAIT;
          busy_cnt_d = '0;
        end
      end
      MDU_WAIT: begin
        if (MduDoneE) begin
          state_d = RUN;
        end else if (timeout_hit) begin
          state_d   = RUN;
          timeout_d = 1'b1;
        end else begin
          busy_cnt_d = busy_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    perf_d = perf_q;
    if (PerfClr) begin
      perf_d = '0;
    end else if (StallFetch && !(&perf_q)) begin
      perf_d = perf_q + PERF_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      busy_cnt_q <= '0;
      timeout_q  <= 1'b0;
      perf_q     <= '0;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
      timeout_q  <= timeout_d;
      perf_q     <= perf_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: expected outputs are queued as each step is
// driven and compared when the step's outputs settle.
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW;
  logic [1:0] ResultSrcE;
  logic       PCSrcE, MduStartE, MduDoneE, DMemReqM, DMemReadyM, PerfClr;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallFetch, StallDecode, StallExecute, StallMemory;
  logic       FlushDecode, FlushExecute, FlushMemory, FlushWriteback;
  logic       MduBusy, MduTimeout;
  logic [7:0] StallCycles;

  typedef struct {
    string      tag;
    logic [13:0] vec;
    logic [7:0]  perf;
  } exp_t;

  exp_t       sb[$];
  int         nChecks = 0;
  int         nFails  = 0;
  logic [7:0] expPerf = 8'd0;

  hazard_unit_mc #(
    .REG_FILE_ADDRESS_WIDTH(5),
    .MDU_TIMEOUT(64),
    .PERF_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE),
    .PCSrcE(PCSrcE), .MduStartE(MduStartE), .MduDoneE(MduDoneE),
    .DMemReqM(DMemReqM), .DMemReadyM(DMemReadyM), .PerfClr(PerfClr),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallFetch(StallFetch), .StallDecode(StallDecode),
    .StallExecute(StallExecute), .StallMemory(StallMemory),
    .FlushDecode(FlushDecode), .FlushExecute(FlushExecute),
    .FlushMemory(FlushMemory), .FlushWriteback(FlushWriteback),
    .MduBusy(MduBusy), .MduTimeout(MduTimeout), .StallCycles(StallCycles)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic sf, input logic sd, input logic se,
                                     input logic sm, input logic fd, input logic fe,
                                     input logic fm, input logic fw, input logic busy,
                                     input logic to);
    return {fa, fb, sf, sd, se, sm, fd, fe, fm, fw, busy, to};
  endfunction

  function automatic logic [13:0] idle(input logic busy, input logic to);
    return mk(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, busy, to);
  endfunction

  function automatic logic [13:0] mduStall(input logic busy, input logic to);
    return mk(2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, busy, to);
  endfunction

  function automatic logic [13:0] memStall(input logic busy, input logic to);
    return mk(2'b00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, busy, to);
  endfunction

  task automatic clearInputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE = 2'b00; PCSrcE = 1'b0;
    MduStartE = 1'b0; MduDoneE = 1'b0; DMemReqM = 1'b0; DMemReadyM = 1'b0; PerfClr = 1'b0;
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [13:0] obs;
    nChecks++;
    assert (sb.size() != 0) else begin
      nFails++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      obs = {ForwardAE, ForwardBE, StallFetch, StallDecode, StallExecute, StallMemory,
             FlushDecode, FlushExecute, FlushMemory, FlushWriteback, MduBusy, MduTimeout};
      nChecks++;
      assert (obs === e.vec) else begin
        nFails++;
        $error("FAIL %s outputs observed=%b expected=%b", e.tag, obs, e.vec);
      end
      nChecks++;
      assert (StallCycles === e.perf) else begin
        nFails++;
        $error("FAIL %s StallCycles observed=%0d expected=%0d", e.tag, StallCycles, e.perf);
      end
    end
  endtask

  // Entered just after a rising edge with inputs already driven; leaves likewise.
  task automatic applyStimulus(input string tag, input logic [13:0] vec);
    sb.push_back('{tag, vec, expPerf});
    @(negedge clk);
    checkOutput();
    if (PerfClr) expPerf = 8'd0;
    else if (vec[9] && expPerf != 8'hFF) expPerf = expPerf + 8'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    clearInputs();
    rst_n = 1'b0;
    #1;
    sb.push_back('{"reset", idle(1'b0, 1'b0), 8'd0});
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    Rs1E = 5'd5; RdM = 5'd5; RdW = 5'd5; RegWriteM = 1'b1; RegWriteW = 1'b1;
    applyStimulus("fwd_a_from_m", mk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    RegWriteM = 1'b0;
    applyStimulus("fwd_a_from_w", mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    Rs1E = 5'd0; RdM = 5'd0; Rs2E = 5'd5;
    applyStimulus("fwd_x0_b_w", mk(2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    RdM = 5'd5; RegWriteM = 1'b1;
    applyStimulus("fwd_b_from_m", mk(2'b00, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    clearInputs();
    ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7; Rs1D = 5'd3;
    applyStimulus("load_use_rs2", mk(2'b00, 2'b00, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    ResultSrcE = 2'b00;
    applyStimulus("load_use_gone", idle(1'b0, 1'b0));
    ResultSrcE = 2'b01; RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
    applyStimulus("load_use_x0", idle(1'b0, 1'b0));
    RdE = 5'd9; Rs1D = 5'd9; PCSrcE = 1'b1;
    applyStimulus("load_use_rs1_branch", mk(2'b00, 2'b00, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0));

    clearInputs();
    PerfClr = 1'b1;
    applyStimulus("perf_clear", idle(1'b0, 1'b0));
    PerfClr = 1'b0;

    MduStartE = 1'b1;
    applyStimulus("mdu_start", mduStall(1'b0, 1'b0));
    for (int i = 1; i <= 4; i++) begin
      MduStartE = (i == 2);
      applyStimulus($sformatf("mdu_wait_%0d", i), mduStall(1'b1, 1'b0));
    end
    MduStartE = 1'b0; MduDoneE = 1'b1;
    applyStimulus("mdu_done", idle(1'b1, 1'b0));
    MduDoneE = 1'b0;
    applyStimulus("mdu_after_count5", idle(1'b0, 1'b0));
    MduStartE = 1'b1; MduDoneE = 1'b1;
    applyStimulus("mdu_start_done", idle(1'b0, 1'b0));
    clearInputs();
    applyStimulus("mdu_no_wait", idle(1'b0, 1'b0));

    DMemReqM = 1'b1; PCSrcE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("mem_wait_%0d", i), memStall(1'b0, 1'b0));
    end
    DMemReadyM = 1'b1;
    applyStimulus("mem_release_redirect", mk(2'b00, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));

    clearInputs();
    MduStartE = 1'b1; DMemReqM = 1'b1;
    applyStimulus("overlap_mem_mdu", memStall(1'b0, 1'b0));
    MduStartE = 1'b0; DMemReadyM = 1'b1;
    applyStimulus("overlap_mdu_only", mduStall(1'b1, 1'b0));
    DMemReqM = 1'b0; DMemReadyM = 1'b0; MduDoneE = 1'b1;
    applyStimulus("overlap_done", idle(1'b1, 1'b0));
    clearInputs();
    applyStimulus("overlap_idle", idle(1'b0, 1'b0));

    DMemReqM = 1'b1;
    for (int i = 0; i < 260; i++) begin
      applyStimulus("perf_saturate", memStall(1'b0, 1'b0));
    end
    clearInputs();
    applyStimulus("perf_hold_max", idle(1'b0, 1'b0));
    PerfClr = 1'b1;
    applyStimulus("perf_clear_max", idle(1'b0, 1'b0));
    PerfClr = 1'b0;
    applyStimulus("perf_after_clear", idle(1'b0, 1'b0));

    MduStartE = 1'b1;
    applyStimulus("wdog_start", mduStall(1'b0, 1'b0));
    MduStartE = 1'b0;
    for (int i = 0; i < 63; i++) begin
      applyStimulus("wdog_wait", mduStall(1'b1, 1'b0));
    end
    applyStimulus("wdog_hit", idle(1'b1, 1'b0));
    applyStimulus("wdog_timeout_set", idle(1'b0, 1'b1));
    applyStimulus("wdog_sticky", idle(1'b0, 1'b1));

    MduStartE = 1'b1;
    applyStimulus("rst_mdu_start", mduStall(1'b0, 1'b1));
    MduStartE = 1'b0;
    applyStimulus("rst_mdu_wait_1", mduStall(1'b1, 1'b1));
    applyStimulus("rst_mdu_wait_2", mduStall(1'b1, 1'b1));
    rst_n = 1'b0;
    expPerf = 8'd0;
    #1;
    sb.push_back('{"reset_mid_wait", idle(1'b0, 1'b0), 8'd0});
    checkOutput();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus("after_reset", idle(1'b0, 1'b0));

    nChecks++;
    assert (sb.size() == 0) else begin
      nFails++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
